led_bounce_seq: RTL

//  Consumes the square wave from the team's LED blink generator and turns each

---
 rtl/led_seq_pkg.sv | 10 +
 rtl/blink_edge_det.sv | 22 ++
 rtl/led_bounce_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED bounce/flash sequencer.
// Enumerator names mirror the state names used by the rest of the team.
package led_seq_pkg;

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, FLASH} state_e;

  localparam logic MODE_BOUNCE = 1'b0;
  localparam logic MODE_FLASH  = 1'b1;

endpackage

// File: rtl/blink_edge_det.sv
// Rising-edge detector for the blink square wave.
// The history flop resets high so a level already high at reset release gives no edge.
module blink_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic blink_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q <= 1'b1;
    end else begin
      blink_q <= in;
    end
  end

  assign rise = in & ~blink_q;

endmodule

// File: rtl/led_bounce_seq.sv
// Steps a bouncing single-LED or whole-bank flash pattern once per blink rising edge,
// for a fixed number of passes per start request.
module led_bounce_seq #(
  parameter  int unsigned N_LED    = 8,
  parameter  int unsigned N_PASSES = 4,
  localparam int unsigned CNT_W    = $clog2(2 * N_PASSES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  output logic [N_LED-1:0] led,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt
);

  import led_seq_pkg::*;

  localparam logic [N_LED-1:0] LED_ONE    = N_LED'(1);
  localparam logic [CNT_W-1:0] BOUNCE_END = CNT_W'(N_PASSES);
  localparam logic [CNT_W-1:0] FLASH_END  = CNT_W'(2 * N_PASSES);

  state_e           state_q, state_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             done_q, done_d;
  logic             tick;

  blink_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (blink),
    .rise (tick)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      led_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        led_d = '0;
        // A tick coinciding with start is deliberately dropped.
        if (start) begin
          cnt_d = '0;
          if (mode == MODE_FLASH) begin
            state_d = FLASH;
            led_d   = '1;
          end else begin
            state_d = LEFT;
            led_d   = LED_ONE;
          end
        end
      end
      LEFT: begin
        if (abort) begin
          state_d = IDLE;
          led_d   = '0;
        end else if (tick) begin
          if (!led_q[N_LED-1]) begin
            led_d = led_q << 1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == BOUNCE_END) begin
              state_d = IDLE;
              led_d   = '0;
              done_d  = 1'b1;
            end else begin
              state_d = RIGHT;
              led_d   = led_q >> 1;
            end
          end
        end
      end
      RIGHT: begin
        if (abort) begin
          state_d = IDLE;
          led_d   = '0;
        end else if (tick) begin
          if (!led_q[0]) begin
            led_d = led_q >> 1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == BOUNCE_END) begin
              state_d = IDLE;
              led_d   = '0;
              done_d  = 1'b1;
            end else begin
              state_d = LEFT;
              led_d   = led_q << 1;
            end
          end
        end
      end
      FLASH: begin
        if (abort) begin
          state_d = IDLE;
          led_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == FLASH_END) begin
            state_d = IDLE;
            led_d   = '0;
            done_d  = 1'b1;
          end else begin
            led_d = ~led_q;
          end
        end
      end
    endcase
  end

  always_comb begin
    led      = led_q;
    busy     = (state_q != IDLE);
    done     = done_q;
    pass_cnt = cnt_q;
  end

endmodule
